modbus_rtu_rx: RTL and testbench

Modbus RTU slave receive path. Deserialises 8N1 UART bytes, delimits frames by bus-idle timeout, and checks CRC-16/Modbus. Decodes function 0x10 (Write Multiple Registers) addressed to this slave and streams the register data bytes to a downstream register-file writer. Sits between the RS-485 RX pin and the application register bank.

---
 rtl/modbus_pkg.sv | 21 ++
 rtl/uart_byte_rx.sv | 67 ++++++
 rtl/modbus_rtu_rx.sv | 128 ++++++++++++
 tb/tb_modbus_rtu_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// Shared constants, FSM state type and the CRC-16/Modbus byte update
// used by the Modbus RTU receive path.
package modbus_pkg;

  localparam logic [7:0]  FUNC_WR_MULTI = 8'h10;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'hA001;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_STREAM} state_t;

  // Reflected CRC-16, one data bit per step, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling,
// start-bit glitch rejection and stop-bit framing check.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_wire,
  output logic [7:0] data,
  output logic       done,
  output logic       busy
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic          sample;

  assign rx_s   = sync[1];
  // bit_cnt 0 = start bit (half period), 1..8 = data, 9 = stop
  assign sample = busy && (clk_cnt == ((bit_cnt == 4'd0) ? HALF : FULL));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      sync    <= {sync[0], uart_rx_wire};
      rx_prev <= rx_s;
      done    <= 1'b0;
      if (!busy) begin
        clk_cnt <= '0;
        bit_cnt <= '0;
        if (rx_prev && !rx_s) busy <= 1'b1;
      end else if (sample) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          done <= rx_s;
        end else if (bit_cnt == 4'd0 && rx_s) begin
          busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample && bit_cnt >= 4'd1 && bit_cnt <= 4'd8) data <= {rx_s, data[7:1]};
  end

endmodule

// File: rtl/modbus_rtu_rx.sv
// Modbus RTU slave receive path: idle-timeout framing, CRC check,
// function 0x10 decode and rd_en-paced streaming of register data bytes.
module modbus_rtu_rx
  import modbus_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115200,
  parameter int         TIMER_OUT  = 17500,
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         MAX_BYTES  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_wire,
  input  logic        rd_en,
  output logic [15:0] mb_reg,
  output logic [15:0] mb_num,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        crc_err
);

  localparam int AW = $clog2(MAX_BYTES);
  localparam logic [7:0]  MAXB = 8'(MAX_BYTES);
  localparam logic [31:0] TOUT = 32'(TIMER_OUT);

  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rx_busy;
  state_t        state;
  logic [7:0]    buf_mem [MAX_BYTES];
  logic [15:0]   crc;
  logic [7:0]    count;
  logic [7:0]    left;
  logic [AW-1:0] rd_ptr;
  logic          ovf;
  logic [31:0]   idle_cnt;
  logic          take;
  logic          len_ok;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk          (clk),
    .rst          (rst_n),
    .uart_rx_wire (uart_rx_wire),
    .data         (rx_data),
    .done         (rx_done),
    .busy         (rx_busy)
  );

  // Bytes landing during CHECK/STREAM are dropped; the sender must keep the gap
  assign take   = rx_done && (state == S_IDLE || state == S_RECV);
  assign len_ok = ({buf_mem[4], buf_mem[5], 1'b0} == {9'h000, buf_mem[6]}) &&
                  ({1'b0, count} == 9'd9 + {1'b0, buf_mem[6]});

  assign wr_en   = (state == S_STREAM) && rd_en;
  assign wr_data = (state == S_STREAM) ? buf_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (take) begin
      crc <= crc16_byte((state == S_IDLE) ? CRC_INIT : crc, rx_data);
      if (state == S_IDLE)  buf_mem[0] <= rx_data;
      else if (count < MAXB) buf_mem[count[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      left     <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      idle_cnt <= '0;
      crc_err  <= 1'b0;
      mb_reg   <= '0;
      mb_num   <= '0;
    end else begin
      if (rx_busy || state != S_RECV) idle_cnt <= '0;
      else if (idle_cnt != TOUT)      idle_cnt <= idle_cnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (rx_done) begin
            count   <= 8'd1;
            ovf     <= 1'b0;
            crc_err <= 1'b0;
            state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (rx_done) begin
            if (count < MAXB) count <= count + 8'd1;
            else              ovf   <= 1'b1;
          end else if (idle_cnt == TOUT) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (!ovf && count >= 8'd4) begin
            // Residual over payload plus appended CRC is zero for a good frame
            if (crc != 16'h0000) begin
              crc_err <= 1'b1;
            end else begin
              crc_err <= 1'b0;
              if (buf_mem[0] == SLAVE_ADDR && buf_mem[1] == FUNC_WR_MULTI && len_ok) begin
                mb_reg <= {buf_mem[2], buf_mem[3]};
                mb_num <= {buf_mem[4], buf_mem[5]};
                rd_ptr <= AW'(7);
                left   <= buf_mem[6];
                if (buf_mem[6] != 8'h00) state <= S_STREAM;
              end
            end
          end
        end
        S_STREAM: begin
          if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            left   <= left - 8'd1;
            if (left == 8'd1) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_rx.sv
// Directed and randomised frames against a frame-level reference model.
module tb_modbus_rtu_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TO       = 400;
  localparam int MAXB     = 32;
  localparam logic [7:0] SADDR = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx_wire;
  logic        rd_en;
  logic [15:0] mb_reg;
  logic [15:0] mb_num;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        crc_err;

  modbus_rtu_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMER_OUT(TO), .SLAVE_ADDR(SADDR), .MAX_BYTES(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_wire(uart_rx_wire), .rd_en(rd_en),
    .mb_reg(mb_reg), .mb_num(mb_num), .wr_en(wr_en), .wr_data(wr_data), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  int          n_asrt = 0;
  int          n_fail = 0;
  int          rd_mode = 0;
  int          rd_viol = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp_data[$];
  logic [15:0] m_reg = 16'h0;
  logic [15:0] m_num = 16'h0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got.push_back(wr_data);
      if (rd_en !== 1'b1) rd_viol++;
    end
  end

  initial begin
    rd_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0:       rd_en = 1'b1;
        1:       rd_en = 1'($urandom_range(0, 1));
        default: rd_en = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [7:0] q[$], input int len);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      c ^= {8'h00, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Frame-level expectations: accept/reject, crc flag, decoded fields, payload
  task automatic model_frame(input logic [7:0] q[$]);
    int n, bc, qty;
    n = q.size();
    exp_data.delete();
    m_err = 1'b0;
    if (n > MAXB || n < 4) return;
    if (crc_of(q, n - 2) != {q[n-1], q[n-2]}) begin
      m_err = 1'b1;
      return;
    end
    if (q[0] != SADDR || q[1] != 8'h10 || n < 9) return;
    bc  = int'(q[6]);
    qty = int'({q[4], q[5]});
    if (n != 9 + bc || bc != 2 * qty) return;
    m_reg = {q[2], q[3]};
    m_num = 16'(qty);
    for (int i = 0; i < bc; i++) exp_data.push_back(q[7+i]);
  endtask

  task automatic make_frame(output logic [7:0] q[$], input logic [7:0] addr, input int qty);
    logic [15:0] c;
    q = {};
    q.push_back(addr);
    q.push_back(8'h10);
    q.push_back(8'($urandom));
    q.push_back(8'($urandom));
    q.push_back(8'(qty >> 8));
    q.push_back(8'(qty));
    q.push_back(8'(2 * qty));
    for (int i = 0; i < 2 * qty; i++) q.push_back(8'($urandom));
    c = crc_of(q, q.size());
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_wire = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_wire = b[i];
      tick(CPB);
    end
    uart_rx_wire = stop;
    tick(CPB);
    uart_rx_wire = 1'b1;
    if (!stop) tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int gap, input int junk_at);
    for (int i = 0; i < q.size(); i++) begin
      if (i == junk_at) begin
        send_byte(8'h55, 1'b0);
        tick(gap);
      end
      send_byte(q[i], 1'b1);
      if (i < q.size() - 1) tick(gap);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] q[$], input int gap,
                           input int mode, input int junk_at);
    int base;
    base = got.size();
    model_frame(q);
    rd_mode = mode;
    send_frame(q, gap, junk_at);
    tick(TO + 10);
    for (int k = 0; k < 4000 && (got.size() - base) < exp_data.size(); k++) tick(1);
    tick(20);
    check({tag, "_nwr"}, got.size() - base, exp_data.size());
    for (int i = 0; i < exp_data.size(); i++)
      check({tag, "_data"}, (base + i < got.size()) ? 32'(got[base+i]) : 32'hFFFF_FFFF, 32'(exp_data[i]));
    check({tag, "_crc_err"}, crc_err, m_err);
    check({tag, "_mb_reg"}, mb_reg, m_reg);
    check({tag, "_mb_num"}, mb_num, m_num);
    check({tag, "_rd_viol"}, rd_viol, 0);
    rd_mode = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick(2);
    rst_n = 1'b0;
    m_reg = 16'h0;
    m_num = 16'h0;
    m_err = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    int base;

    uart_rx_wire = 1'b1;
    rst_n = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(3);
    check("rst_mb_reg", mb_reg, 0);
    check("rst_mb_num", mb_num, 0);
    check("rst_crc_err", crc_err, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);

    q = {8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h41, 8'h30, 8'h00, 8'h00, 8'hE7, 8'h9C};
    run_frame("ref_frame", q, 0, 0, -1);
    q[12] = 8'h9D;
    run_frame("bad_crc", q, 0, 0, -1);
    q = {8'h01, 8'h10, 8'h00};
    run_frame("short", q, 0, 0, -1);

    make_frame(q, 8'h02, 2);
    run_frame("other_addr", q, 0, 0, -1);

    for (int r = 0; r < 3; r++) begin
      make_frame(q, SADDR, $urandom_range(1, 11));
      run_frame("rand_toggle", q, $urandom_range(0, 40), 1, -1);
    end
    make_frame(q, SADDR, 3);
    run_frame("bad_stop_junk", q, 0, 1, 4);
    make_frame(q, SADDR, 11);
    run_frame("max_len", q, 0, 0, -1);
    make_frame(q, SADDR, 12);
    run_frame("overflow", q, 0, 0, -1);

    make_frame(q, SADDR, 2);
    run_frame("half_gap", q, TO / 2, 0, -1);

    make_frame(q, SADDR, 2);
    p1 = {};
    p2 = {};
    for (int i = 0; i < q.size(); i++) begin
      if (i < 5) p1.push_back(q[i]);
      else       p2.push_back(q[i]);
    end
    run_frame("split_a", p1, 0, 0, -1);
    run_frame("split_b", p2, 0, 0, -1);

    make_frame(q, SADDR, 1);
    run_frame("pre_reset", q, 0, 0, -1);
    make_frame(q, SADDR, 2);
    base = got.size();
    for (int i = 0; i < 6; i++) send_byte(q[i], 1'b1);
    do_reset();
    check("midframe_mb_reg", mb_reg, 0);
    check("midframe_mb_num", mb_num, 0);
    check("midframe_wr_en", wr_en, 0);
    tick(TO + 50);
    check("midframe_nwr", got.size() - base, 0);
    check("midframe_crc_err", crc_err, 0);
    make_frame(q, SADDR, 2);
    run_frame("post_reset", q, 0, 0, -1);

    make_frame(q, SADDR, 3);
    model_frame(q);
    base = got.size();
    rd_mode = 2;
    send_frame(q, 0, -1);
    tick(TO + 30);
    check("stall_nwr", got.size() - base, 0);
    check("stall_mb_reg", mb_reg, m_reg);
    do_reset();
    rd_mode = 0;
    tick(60);
    check("midstream_nwr", got.size() - base, 0);
    check("midstream_mb_num", mb_num, 0);
    make_frame(q, SADDR, 4);
    run_frame("final", q, 0, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
